// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_t;

  // Parity bit for a zero-extended data word; odd mode inverts the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick prescaler; divisor is captured on restart.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, div_q;

  // Count 0..div_q, wrapping; restart zeroes the count and latches a new divisor.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      div_q <= '0;
    end else if (restart_i) begin
      cnt_q <= '0;
      div_q <= div_i;
    end else if (cnt_q == div_q) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == div_q);

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: independent TX and RX engines, each with its own prescaler.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 tx_o,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_overrun_o
);

  localparam int unsigned    OsW       = $clog2(OVERSAMPLE);
  localparam logic [OsW-1:0] OsLast    = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0] OsHalf    = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     DataLast  = 4'(DATA_BITS - 1);
  localparam logic [3:0]     StopLast  = 4'(STOP_BITS - 1);
  localparam logic [1:0]     ParMode   = 2'(PARITY);
  localparam logic           HasParity = (ParMode != PAR_NONE);

  // ---------------- TX engine ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [OsW-1:0]       tx_os_q, tx_os_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_restart, tx_tick, tx_bit_end;

  uart_baud_gen #(.DIV_W(DIV_W)) u_tx_baud (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .restart_i(tx_restart),
    .div_i    (baud_div_i),
    .tick_o   (tx_tick)
  );

  // TX state register; line idles high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q <= TxIdle;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_os_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_os_q    <= tx_os_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state: the next bit value is registered on the last tick of the current bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_os_d    = tx_os_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_restart = 1'b0;
    tx_bit_end = tx_tick && (tx_os_q == OsLast);
    if (tx_state_q != TxIdle && tx_tick) tx_os_d = tx_bit_end ? '0 : tx_os_q + 1'b1;
    unique case (tx_state_q)
      TxIdle: if (tx_valid_i) begin
        tx_restart = 1'b1;
        tx_shift_d = tx_data_i;
        tx_par_d   = parity_bit(9'(tx_data_i), ParMode);
        tx_os_d    = '0;
        tx_d       = 1'b0;
        tx_state_d = TxStart;
      end
      TxStart: if (tx_bit_end) begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = '0;
        tx_state_d = TxData;
      end
      TxData: if (tx_bit_end) begin
        if (tx_bit_q == DataLast) begin
          tx_bit_d = '0;
          if (HasParity) begin
            tx_d       = tx_par_q;
            tx_state_d = TxParity;
          end else begin
            tx_d       = 1'b1;
            tx_state_d = TxStop;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TxParity: if (tx_bit_end) begin
        tx_d       = 1'b1;
        tx_bit_d   = '0;
        tx_state_d = TxStop;
      end
      TxStop: if (tx_bit_end) begin
        if (tx_bit_q == StopLast) tx_state_d = TxIdle;
        else                      tx_bit_d   = tx_bit_q + 4'd1;
        tx_d = 1'b1;
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = (tx_state_q == TxIdle);
  assign tx_busy_o  = ~tx_ready_o;

  // ---------------- RX engine ----------------
  rx_state_t            rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [OsW-1:0]       rx_os_q, rx_os_d;
  logic                 rx_armed_q, rx_armed_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 rx_restart, rx_tick, rx_sample, rx_done;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_ferr_out_q, rx_perr_out_q, rx_ovr_q;

  uart_baud_gen #(.DIV_W(DIV_W)) u_rx_baud (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .restart_i(rx_restart),
    .div_i    (baud_div_i),
    .tick_o   (rx_tick)
  );

  // Synchroniser resets low so a line that is low out of reset cannot arm the receiver.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b0;
      rx_s_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // RX state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state_q <= RxIdle;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_os_q    <= '0;
      rx_armed_q <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_os_q    <= rx_os_d;
      rx_armed_q <= rx_armed_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // RX next state: half a bit to the start centre, then one full bit per sample.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_os_d    = rx_os_q;
    rx_armed_d = rx_armed_q;
    rx_perr_d  = rx_perr_q;
    rx_restart = 1'b0;
    rx_done    = 1'b0;
    rx_sample  = rx_tick && (rx_os_q == ((rx_state_q == RxStart) ? OsHalf : OsLast));
    if (rx_state_q != RxIdle && rx_tick) rx_os_d = rx_sample ? '0 : rx_os_q + 1'b1;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_s_q) begin
          rx_armed_d = 1'b1;
        end else if (rx_armed_q) begin
          rx_armed_d = 1'b0;
          rx_restart = 1'b1;
          rx_os_d    = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: if (rx_sample) begin
        if (rx_s_q) begin
          rx_state_d = RxIdle;  // glitch, not a start bit
        end else begin
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_state_d = RxData;
        end
      end
      RxData: if (rx_sample) begin
        rx_shift_d = {rx_s_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == DataLast) rx_state_d = HasParity ? RxParity : RxStop;
        else                      rx_bit_d   = rx_bit_q + 4'd1;
      end
      RxParity: if (rx_sample) begin
        rx_perr_d  = rx_s_q ^ parity_bit(9'(rx_shift_q), ParMode);
        rx_state_d = RxStop;
      end
      RxStop: if (rx_sample) begin
        rx_done    = 1'b1;
        rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // One-entry output register; a full, unconsumed entry drops the new word and flags overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_ferr_out_q <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ovr_q      <= 1'b0;
    end else begin
      rx_ovr_q <= 1'b0;
      if (rx_done && (!rx_valid_q || rx_ready_i)) begin
        rx_data_q     <= rx_shift_q;
        rx_ferr_out_q <= ~rx_s_q;
        rx_perr_out_q <= rx_perr_q;
        rx_valid_q    <= 1'b1;
      end else if (rx_done) begin
        rx_ovr_q <= 1'b1;
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_frame_err_o  = rx_ferr_out_q;
  assign rx_parity_err_o = rx_perr_out_q;
  assign rx_overrun_o    = rx_ovr_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: TX waveform, loopback, parity, RX errors, overrun, reset.
module tb_uart_xcvr;

  localparam int BitT = 64;  // (baud_div + 1) * OVERSAMPLE with baud_div = 3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_valid_e, tx_valid_od;
  logic        rx_drv, loop_sel, rx_ready_m;
  logic        rx_in_m;

  logic       tx_ready_m, tx_busy_m, tx_m, rx_valid_m, rx_ferr_m, rx_perr_m, rx_ovr_m;
  logic [7:0] rx_data_m;
  logic       tx_ready_e, tx_busy_e, tx_e, rx_valid_e, rx_ferr_e, rx_perr_e, rx_ovr_e;
  logic [7:0] rx_data_e;
  logic       tx_ready_od, tx_busy_od, tx_od, rx_valid_od, rx_ferr_od, rx_perr_od, rx_ovr_od;
  logic [7:0] rx_data_od;

  assign rx_in_m = loop_sel ? tx_m : rx_drv;

  uart_xcvr #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_m), .tx_busy_o(tx_busy_m), .tx_o(tx_m),
    .rx_i(rx_in_m), .rx_data_o(rx_data_m), .rx_valid_o(rx_valid_m), .rx_ready_i(rx_ready_m),
    .rx_frame_err_o(rx_ferr_m), .rx_parity_err_o(rx_perr_m), .rx_overrun_o(rx_ovr_m)
  );

  uart_xcvr #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut_even (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid_e), .tx_ready_o(tx_ready_e), .tx_busy_o(tx_busy_e), .tx_o(tx_e),
    .rx_i(rx_drv), .rx_data_o(rx_data_e), .rx_valid_o(rx_valid_e), .rx_ready_i(1'b1),
    .rx_frame_err_o(rx_ferr_e), .rx_parity_err_o(rx_perr_e), .rx_overrun_o(rx_ovr_e)
  );

  uart_xcvr #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_W(16)) dut_odd (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid_od), .tx_ready_o(tx_ready_od), .tx_busy_o(tx_busy_od), .tx_o(tx_od),
    .rx_i(rx_drv), .rx_data_o(rx_data_od), .rx_valid_o(rx_valid_od), .rx_ready_i(1'b1),
    .rx_frame_err_o(rx_ferr_od), .rx_parity_err_o(rx_perr_od), .rx_overrun_o(rx_ovr_od)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accepted words, packed as {frame_err, parity_err, data}.
  logic [9:0] main_q[$];
  logic [9:0] even_q[$];
  int         ovr_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid_m && rx_ready_m) main_q.push_back({rx_ferr_m, rx_perr_m, rx_data_m});
    if (rx_valid_e) even_q.push_back({rx_ferr_e, rx_perr_e, rx_data_e});
    if (rx_ovr_m) ovr_cnt++;
  end

  function automatic logic [15:0] frame_seq(input logic [7:0] d, input logic par_en,
                                            input logic par_bit, input logic stop);
    logic [15:0] s;
    s      = '1;
    s[0]   = 1'b0;
    s[8:1] = d;
    if (par_en) begin
      s[9]  = par_bit;
      s[10] = stop;
    end else begin
      s[9] = stop;
    end
    return s;
  endfunction

  // Drive bits LSB first, each for one bit period; call just after a posedge.
  task automatic drive_bits(input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = seq[i];
      repeat (BitT) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] seq;
    logic [7:0]  lb_bytes [3];
    logic [9:0]  w;
    int          main_rd;
    int          even_rd;
    int          base;

    lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A;
    main_rd = 0; even_rd = 0;
    rst = 1'b1; baud_div = 16'd3; tx_data = '0;
    tx_valid = 0; tx_valid_e = 0; tx_valid_od = 0;
    rx_drv = 1'b1; loop_sel = 1'b0; rx_ready_m = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tx", 32'(tx_m), 32'd1);
    check("reset_tx_ready", 32'(tx_ready_m), 32'd1);
    check("reset_tx_busy", 32'(tx_busy_m), 32'd0);
    check("reset_rx_valid", 32'(rx_valid_m), 32'd0);
    check("reset_rx_data", 32'(rx_data_m), 32'd0);
    check("reset_errs", 32'({rx_ferr_m, rx_perr_m, rx_ovr_m}), 32'd0);
    repeat (8) @(posedge clk);

    // TX 0xA5: start on cycle 1, ten bits of 64 cycles, ready again at 641.
    #1 tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    seq = frame_seq(8'hA5, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 641; i++) begin
      @(negedge clk);
      if (i <= 640 && ((i % BitT) == 1 || (i % BitT) == 0))
        check($sformatf("tx_a5_cyc%0d", i), 32'(tx_m), 32'(seq[(i - 1) / BitT]));
      if (i == 1)   check("tx_busy_during", 32'(tx_busy_m), 32'd1);
      if (i == 640) check("tx_ready_last_stop", 32'(tx_ready_m), 32'd0);
      if (i == 641) check("tx_ready_return", 32'(tx_ready_m), 32'd1);
    end

    // Loopback of three back-to-back bytes.
    @(posedge clk);
    #1 loop_sel = 1'b1;
    main_rd = main_q.size();
    for (int b = 0; b < 3; b++) begin
      tx_data = lb_bytes[b]; tx_valid = 1'b1;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        if (tx_ready_m) break;
      end
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    for (int k = 0; k < 1200 && main_q.size() - main_rd < 3; k++) @(negedge clk);
    check("loop_count", 32'(main_q.size() - main_rd), 32'd3);
    for (int b = 0; b < 3; b++) begin
      if (main_q.size() > main_rd) begin
        w = main_q[main_rd]; main_rd++;
        check($sformatf("loop_word%0d", b), 32'(w), {22'd0, 2'b00, lb_bytes[b]});
      end
    end
    repeat (BitT) @(posedge clk);
    #1 loop_sel = 1'b0;

    // Parity on TX: 0x03 has two ones, so even gives 0, odd gives 1.
    tx_data = 8'h03; tx_valid_e = 1'b1; tx_valid_od = 1'b1;
    @(posedge clk);
    #1 tx_valid_e = 1'b0; tx_valid_od = 1'b0;
    for (int i = 1; i <= 705; i++) begin
      @(negedge clk);
      if (i == BitT + 32)     check("even_tx_d0", 32'(tx_e), 32'd1);
      if (i == 9 * BitT + 32) check("even_tx_parity", 32'(tx_e), 32'd0);
      if (i == 9 * BitT + 32) check("odd_tx_parity", 32'(tx_od), 32'd1);
      if (i == 10 * BitT + 32) check("odd_tx_stop", 32'(tx_od), 32'd1);
      if (i == 705)           check("even_tx_ready", 32'(tx_ready_e), 32'd1);
    end

    // Corrupted parity into the even receiver.
    @(posedge clk);
    #1 even_rd = even_q.size();
    drive_bits(frame_seq(8'h03, 1'b1, 1'b1, 1'b1), 11);
    for (int k = 0; k < 200 && even_q.size() - even_rd < 1; k++) @(negedge clk);
    check("par_err_count", 32'(even_q.size() - even_rd), 32'd1);
    if (even_q.size() > even_rd) check("par_err_word", 32'(even_q[even_rd]), 32'h103);
    repeat (BitT) @(posedge clk);
    #1 main_rd = main_q.size();

    // False start: 20 low cycles, then a normal frame must still be received.
    rx_drv = 1'b0;
    repeat (20) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (2 * BitT) @(posedge clk);
    check("false_start_none", 32'(main_q.size() - main_rd), 32'd0);
    #1 drive_bits(frame_seq(8'h3C, 1'b0, 1'b0, 1'b1), 10);
    for (int k = 0; k < 200 && main_q.size() - main_rd < 1; k++) @(negedge clk);
    check("after_false_count", 32'(main_q.size() - main_rd), 32'd1);
    if (main_q.size() > main_rd) begin
      check("after_false_word", 32'(main_q[main_rd]), 32'h03C);
      main_rd++;
    end

    // Stop bit 0 then held low: one word with frame error, no retrigger.
    @(posedge clk);
    #1 drive_bits(frame_seq(8'h81, 1'b0, 1'b0, 1'b0), 10);
    repeat (3 * BitT) @(posedge clk);
    check("break_count", 32'(main_q.size() - main_rd), 32'd1);
    if (main_q.size() > main_rd) begin
      check("frame_err_word", 32'(main_q[main_rd]), 32'h281);
      main_rd++;
    end
    #1 rx_drv = 1'b1;
    repeat (2 * BitT) @(posedge clk);
    check("break_release_none", 32'(main_q.size() - main_rd), 32'd0);

    // Overrun: two frames with rx_ready low.
    #1 rx_ready_m = 1'b0;
    base = ovr_cnt;
    drive_bits(frame_seq(8'h11, 1'b0, 1'b0, 1'b1), 10);
    drive_bits(frame_seq(8'h22, 1'b0, 1'b0, 1'b1), 10);
    repeat (BitT) @(posedge clk);
    @(negedge clk);
    check("ovr_valid_held", 32'(rx_valid_m), 32'd1);
    check("ovr_first_word", 32'(rx_data_m), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    @(posedge clk);
    #1 rx_ready_m = 1'b1;
    repeat (4) @(posedge clk);
    check("ovr_consumed", 32'(main_q.size() - main_rd), 32'd1);
    if (main_q.size() > main_rd) begin
      check("ovr_consumed_word", 32'(main_q[main_rd]), 32'h011);
      main_rd++;
    end
    @(negedge clk);
    check("ovr_valid_cleared", 32'(rx_valid_m), 32'd0);

    // Reset in the middle of a TX frame and an RX frame.
    @(posedge clk);
    #1 tx_data = 8'h00; tx_valid = 1'b1;
    fork
      begin
        @(posedge clk);
        #1 tx_valid = 1'b0;
      end
      drive_bits(frame_seq(8'h00, 1'b0, 1'b0, 1'b1), 10);
      begin
        repeat (300) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_tx", 32'(tx_m), 32'd1);
        check("rst_mid_tx_ready", 32'(tx_ready_m), 32'd1);
        rst = 1'b0;
      end
    join
    repeat (2 * BitT) @(posedge clk);
    @(negedge clk);
    check("rst_mid_rx_none", 32'(main_q.size() - main_rd), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_m), 32'd0);
    check("rst_tx_idle", 32'(tx_m), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
